fetch_queue: RTL and testbench

- Instruction prefetch buffer between the PC/instruction-memory fetch stage and the decode stage of the P6 pipeline.
- Fetch pushes {pc, instr} pairs. Decode pops them with a ready/valid handshake.
- A redirect flush discards wrong-path entries and preserves the branch delay slot.
- Lets fetch keep running while decode stalls. Fetch's stall input is driven from ~in_ready.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_ram.sv | 33 +++
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: reset PC, NOP encoding and the queue entry
// payload (pc + instr) used by fetch_queue and its storage array.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_3000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue.
//   master : fetch + decode side (drives in_*, out_ready, flush)
//   slave  : the queue (drives in_ready, out_*, count)
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 2
);

  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;
  logic            flush;
  logic [ADDR_W:0] count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x fetch_entry_t register array: one synchronous write port,
// one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : entry to store
//   raddr : read index
//   rdata : entry at raddr (combinational)
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fetch_entry_t      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output fetch_entry_t      rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Fetch pushes
// {pc, instr}; decode pops with ready/valid. A flush keeps only the oldest
// surviving entry (branch delay slot), or captures the incoming pair if
// nothing survives.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   q     : fetch_queue_if.slave (push side, pop side, flush, count)
// Optional (FETCH_QUEUE_STATS_EN):
//   stall_cycles : cycles with in_valid & ~in_ready (saturating)
//   flush_count  : cycles with flush asserted (saturating)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     ADDR_W   = 2,
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic             clk,
  input  logic             reset,
  fetch_queue_if.slave     q
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, rem;
  logic              push, pop, we;
  fetch_entry_t      wdata, rdata;

  // Handshake depends only on registered occupancy.
  assign q.in_ready  = (cnt != FULL);
  assign q.out_valid = (cnt != '0);
  assign push        = q.in_valid & q.in_ready;
  assign pop         = q.out_valid & q.out_ready;
  assign rem         = cnt - CNT_W'(pop);

  // Next pointer/count; flush resolves the pop first, then keeps one entry.
  always_comb begin
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = cnt;
    we      = 1'b0;
    if (q.flush) begin
      if (rem != '0) begin
        rd_nxt  = rd_ptr + ADDR_W'(pop);
        wr_nxt  = rd_nxt + ADDR_W'(1);
        cnt_nxt = CNT_W'(1);
      end else if (push) begin
        // Nothing survives, so rd_ptr+pop already equals wr_ptr.
        we      = 1'b1;
        rd_nxt  = wr_ptr;
        wr_nxt  = wr_ptr + ADDR_W'(1);
        cnt_nxt = CNT_W'(1);
      end else begin
        rd_nxt  = rd_ptr + ADDR_W'(pop);
        cnt_nxt = '0;
      end
    end else begin
      we      = push;
      wr_nxt  = wr_ptr + ADDR_W'(push);
      rd_nxt  = rd_ptr + ADDR_W'(pop);
      cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign wdata.pc    = q.in_pc;
  assign wdata.instr = q.in_instr;

  fetch_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we & reset),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign q.out_pc    = (cnt == '0) ? RESET_PC  : rdata.pc;
  assign q.out_instr = (cnt == '0) ? INSTR_NOP : rdata.instr;
  assign q.count     = cnt;

`ifdef FETCH_QUEUE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (q.in_valid && !q.in_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (q.flush && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue with a scoreboard model of queue contents.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_entry_t sb[$];

  fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  fetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_3000)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Drive one cycle of stimulus, update the model, advance past the edge.
  task automatic step(input logic iv, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit           psh;
    bit           pp;
    fetch_entry_t e;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = ordy;
    bus.flush     = fl;
    psh = iv && (sb.size() < DEPTH);
    pp  = ordy && (sb.size() > 0);
    e.pc    = pc;
    e.instr = instr_of(pc);
    if (pp) void'(sb.pop_front());
    if (fl) begin
      if (sb.size() >= 1) begin
        while (sb.size() > 1) void'(sb.pop_back());
      end else if (psh) begin
        sb.push_back(e);
      end
    end else if (psh) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", bus.count);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_pc !== 32'h0000_3000 || bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_out_pc got=%h/%h exp=00003000/00000000",
                         bus.out_pc, bus.out_instr);
    end
`ifdef FETCH_QUEUE_STATS_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
`endif
  endtask

  task automatic test_fill_block();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got=count %0d rdy %b exp=count 4 rdy 0",
                         bus.count, bus.in_ready);
    end
    step(1'b1, 32'h3010, 1'b0, 1'b0);
`ifdef FETCH_QUEUE_STATS_EN
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL stall_cycles got=%0d exp=1", stall_cycles);
    end
`endif
    checks++;
    if (bus.count !== 3'(sb.size())) begin
      errors++; $display("FAIL full_push_ignored got=%0d exp=%0d", bus.count, sb.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3000 + 32'(4 * i) ||
          bus.out_instr !== sb[0].instr) begin
        errors++; $display("FAIL drain_%0d got=v%b %h/%h exp=v1 %h/%h", i, bus.out_valid,
                           bus.out_pc, bus.out_instr, 32'h3000 + 32'(4 * i), sb[0].instr);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0000_3000) begin
      errors++; $display("FAIL drain_empty got=v%b %h exp=v0 00003000",
                         bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h4000, 1'b0, 1'b0);
    step(1'b1, 32'h4004, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.count !== 3'd2 || bus.out_pc !== sb[0].pc || bus.out_instr !== sb[0].instr) begin
        errors++; $display("FAIL b2b_%0d got=count %0d pc %h exp=count 2 pc %h",
                           i, bus.count, bus.out_pc, sb[0].pc);
      end
      step(1'b1, 32'h4008 + 32'(4 * i), 1'b1, 1'b0);
    end
    while (sb.size() > 0) begin
      checks++;
      if (bus.out_pc !== sb[0].pc) begin
        errors++; $display("FAIL b2b_drain got=%h exp=%h", bus.out_pc, sb[0].pc);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush_delay_slot();
    step(1'b1, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h3008, 1'b0, 1'b0);
    step(1'b1, 32'h300C, 1'b1, 1'b1);
    checks++;
    if (bus.count !== 3'd1 || bus.out_pc !== 32'h3004 || sb.size() != 1) begin
      errors++; $display("FAIL flush_keep got=count %0d pc %h exp=count 1 pc 00003004",
                         bus.count, bus.out_pc);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped_push got=count %0d exp=0", bus.count);
    end
  endtask

  task automatic test_flush_empty();
    step(1'b1, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 1'b1, 1'b1);
    checks++;
    if (bus.count !== 3'd1 || bus.out_pc !== 32'h3004 ||
        bus.out_instr !== instr_of(32'h3004)) begin
      errors++; $display("FAIL flush_empty got=count %0d pc %h exp=count 1 pc 00003004",
                         bus.count, bus.out_pc);
    end
    // Pop the only entry under flush with no push: queue empties.
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_to_zero got=count %0d exp=0", bus.count);
    end
`ifdef FETCH_QUEUE_STATS_EN
    checks++;
    if (flush_count !== 32'd3) begin
      errors++; $display("FAIL flush_count got=%0d exp=3", flush_count);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 32'h5000, 1'b0, 1'b0);
    step(1'b1, 32'h5004, 1'b0, 1'b0);
    step(1'b1, 32'h5008, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h500C;
    bus.in_instr  = instr_of(32'h500C);
    bus.out_ready = 1'b1;
    reset         = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=count %0d v%b exp=count 0 v0",
                         bus.count, bus.out_valid);
    end
    step(1'b1, 32'h6000, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h6000 || bus.count !== 3'd1) begin
      errors++; $display("FAIL post_reset_push got=v%b pc %h count %0d exp=v1 pc 00006000 count 1",
                         bus.out_valid, bus.out_pc, bus.count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    test_reset();
    test_fill_block();
    test_back_to_back();
    test_flush_delay_slot();
    test_flush_empty();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
